// File: rtl/main_memory_responder.sv
// Word-addressed backing RAM with fixed access latency, servicing flush (write)
// and fetch (read) handshakes with one-cycle acks and per-type completion counters.
module main_memory_responder #(
    parameter int address_space = 12,
    parameter int data_size     = 32,
    parameter int latency       = 4,
    parameter int count_width   = 16
) (
    input  logic                     clka,
    input  logic                     rsta,
    input  logic                     fetch,
    input  logic                     flush,
    input  logic [address_space-1:0] addr,
    input  logic [data_size-1:0]     wdata,
    output logic [data_size-1:0]     rdata,
    output logic                     fetch_ack,
    output logic                     flush_ack,
    output logic                     busy,
    output logic [count_width-1:0]   fetch_count,
    output logic [count_width-1:0]   flush_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] ACK     = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int                     depth      = 2 ** address_space;
    localparam logic [7:0]             load_value = 8'(latency - 1);
    localparam logic [7:0]             delay_one  = 8'd1;
    localparam logic [count_width-1:0] count_one  = count_width'(1);

    logic [1:0]               state;
    logic                     op;
    logic [7:0]               delay;
    logic [address_space-1:0] addr_q;
    logic [data_size-1:0]     wdata_q;
    logic [data_size-1:0]     mem [0:depth-1];
    logic                     access;

    // The array access happens on the counter-zero edge that enters ACK.
    assign access = (state == WAIT) && (delay == 8'd0);
    assign busy   = (state != IDLE);

    always_ff @(posedge clka) begin
        if (rsta) begin
            state       <= IDLE;
            op          <= OP_READ;
            delay       <= 8'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata       <= '0;
            fetch_ack   <= 1'b0;
            flush_ack   <= 1'b0;
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            // NOTE: acks default low each cycle so any pulse lasts exactly one clock.
            fetch_ack <= 1'b0;
            flush_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        op      <= OP_WRITE;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        delay   <= load_value;
                        state   <= WAIT;
                    end else if (fetch) begin
                        op     <= OP_READ;
                        addr_q <= addr;
                        delay  <= load_value;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (delay != 8'd0) begin
                        delay <= delay - delay_one;
                    end else begin
                        state <= ACK;
                        if (op == OP_WRITE) begin
                            flush_ack   <= 1'b1;
                            flush_count <= flush_count + count_one;
                        end else begin
                            fetch_ack   <= 1'b1;
                            rdata       <= mem[addr_q];
                            fetch_count <= fetch_count + count_one;
                        end
                    end
                end
                ACK: state <= RELEASE;
                RELEASE: begin
                    // Only the serviced line matters; a pending other request waits in IDLE.
                    if ((op == OP_WRITE) ? !flush : !fetch) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the array is deliberately not reset; reset only blocks a same-edge commit.
    always_ff @(posedge clka) begin
        if (!rsta && access && (op == OP_WRITE)) mem[addr_q] <= wdata_q;
    end

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: latency, ack pulses, priority,
// hold-past-ack, reset abort and counter wrap on a latency=1 / 2-bit build.
module tb_main_memory_responder;

    logic        clka = 1'b0;
    logic        rsta = 1'b1;
    logic        fetch = 1'b0, flush = 1'b0;
    logic [11:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        fetch_ack, flush_ack, busy;
    logic [15:0] fetch_count, flush_count;

    logic        fetch1 = 1'b0, flush1 = 1'b0;
    logic [11:0] addr1 = '0;
    logic [31:0] wdata1 = '0;
    logic [31:0] rdata1;
    logic        fetch_ack1, flush_ack1, busy1;
    logic [1:0]  fetch_count1, flush_count1;

    int assertions = 0;
    int failures   = 0;
    int both_acks  = 0;

    main_memory_responder u_dut (
        .clka(clka), .rsta(rsta), .fetch(fetch), .flush(flush), .addr(addr), .wdata(wdata),
        .rdata(rdata), .fetch_ack(fetch_ack), .flush_ack(flush_ack), .busy(busy),
        .fetch_count(fetch_count), .flush_count(flush_count)
    );

    main_memory_responder #(.latency(1), .count_width(2)) u_fast (
        .clka(clka), .rsta(rsta), .fetch(fetch1), .flush(flush1), .addr(addr1), .wdata(wdata1),
        .rdata(rdata1), .fetch_ack(fetch_ack1), .flush_ack(flush_ack1), .busy(busy1),
        .fetch_count(fetch_count1), .flush_count(flush_count1)
    );

    always #5 clka = ~clka;

    always @(negedge clka) if (fetch_ack && flush_ack) both_acks++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertions++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Request is dropped 'hold' cycles after the ack is seen.
    task automatic xfer(input bit is_wr, input logic [11:0] a, input logic [31:0] d,
                        input int hold, output int lat, output int acks, output logic [31:0] rd);
        logic ack;
        lat  = -1;
        acks = 0;
        rd   = 'x;
        addr  = a;
        wdata = d;
        if (is_wr) flush = 1'b1; else fetch = 1'b1;
        for (int n = 0; n < 64; n++) begin
            @(posedge clka);
            @(negedge clka);
            if (n == 0) begin
                check("busy_rise", {31'd0, busy}, 32'd1);
                addr  = ~a;
                wdata = ~d;
            end
            ack = is_wr ? flush_ack : fetch_ack;
            if (ack) begin
                acks++;
                if (lat < 0) begin
                    lat = n;
                    rd  = rdata;
                end
            end
            if (lat >= 0 && n >= lat + hold) break;
        end
        flush = 1'b0;
        fetch = 1'b0;
        for (int n = 0; n < 8 && busy; n++) begin
            @(posedge clka);
            @(negedge clka);
            if (is_wr ? flush_ack : fetch_ack) acks++;
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 16 && busy; n++) @(negedge clka);
    endtask

    initial begin
        int          lat, acks, fa, fe;
        logic [31:0] rd;

        @(posedge clka);
        @(negedge clka);
        check("rst_rdata", rdata, 32'd0);
        check("rst_acks", {30'd0, fetch_ack, flush_ack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_counts", {fetch_count, flush_count}, 32'd0);
        rsta = 1'b0;
        @(negedge clka);

        // Test 1: basic flush
        xfer(1'b1, 12'h0A5, 32'hDEADBEEF, 0, lat, acks, rd);
        check("t1_latency", lat, 32'd4);
        check("t1_acks", acks, 32'd1);
        check("t1_flush_count", {16'd0, flush_count}, 32'd1);
        check("t1_fetch_count", {16'd0, fetch_count}, 32'd0);
        check("t1_busy_low", {31'd0, busy}, 32'd0);

        // Test 2: read back, rdata held
        xfer(1'b0, 12'h0A5, 32'h0, 0, lat, acks, rd);
        check("t2_latency", lat, 32'd4);
        check("t2_rdata", rd, 32'hDEADBEEF);
        check("t2_fetch_count", {16'd0, fetch_count}, 32'd1);
        repeat (10) @(negedge clka);
        check("t2_rdata_held", rdata, 32'hDEADBEEF);

        // Test 3: simultaneous requests, flush first then pending fetch
        flush = 1'b1;
        fetch = 1'b1;
        addr  = 12'h010;
        wdata = 32'h12345678;
        fa = -1;
        fe = -1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clka);
            @(negedge clka);
            if (flush_ack && fa < 0) begin
                fa = n;
                flush = 1'b0;
            end
            if (fetch_ack) begin
                fe = n;
                rd = rdata;
                fetch = 1'b0;
                break;
            end
        end
        flush = 1'b0;
        fetch = 1'b0;
        wait_idle();
        check("t3_flush_ack_cycle", fa, 32'd4);
        check("t3_fetch_ack_cycle", fe, 32'd11);
        check("t3_rdata", rd, 32'h12345678);
        check("t3_counts", {fetch_count, flush_count}, {16'd2, 16'd2});

        // Test 4: flush held 3 cycles past ack, data changes meanwhile
        xfer(1'b1, 12'h0B0, 32'h0BADC0DE, 3, lat, acks, rd);
        check("t4_acks", acks, 32'd1);
        check("t4_flush_count", {16'd0, flush_count}, 32'd3);
        xfer(1'b0, 12'h0B0, 32'h0, 0, lat, acks, rd);
        check("t4_readback", rd, 32'h0BADC0DE);

        // Test 5: known contents, then reset during WAIT of an overwrite
        xfer(1'b1, 12'h020, 32'h55AA55AA, 0, lat, acks, rd);
        check("t5_pre_flush_count", {16'd0, flush_count}, 32'd4);
        addr  = 12'h020;
        wdata = 32'hCAFEF00D;
        flush = 1'b1;
        @(posedge clka);
        @(posedge clka);
        @(negedge clka);
        rsta  = 1'b1;
        flush = 1'b0;
        @(posedge clka);
        @(negedge clka);
        check("t5_rst_rdata", rdata, 32'd0);
        check("t5_rst_counts", {fetch_count, flush_count}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        rsta = 1'b0;
        acks = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clka);
            if (flush_ack || fetch_ack) acks++;
        end
        check("t5_no_ack", acks, 32'd0);
        xfer(1'b0, 12'h020, 32'h0, 0, lat, acks, rd);
        check("t5_old_contents", rd, 32'h55AA55AA);
        xfer(1'b1, 12'h020, 32'h00000001, 0, lat, acks, rd);
        xfer(1'b0, 12'h020, 32'h0, 0, lat, acks, rd);
        check("t5_new_contents", rd, 32'h00000001);
        check("t5_counts", {fetch_count, flush_count}, {16'd2, 16'd1});
        check("no_double_ack", both_acks, 32'd0);

        // Test 6: latency=1, 2-bit counter wraps
        for (int i = 0; i < 5; i++) begin
            addr1  = 12'(i);
            fetch1 = 1'b1;
            lat = -1;
            for (int n = 0; n < 16; n++) begin
                @(posedge clka);
                @(negedge clka);
                if (fetch_ack1) begin
                    lat = n;
                    break;
                end
            end
            fetch1 = 1'b0;
            for (int n = 0; n < 16 && busy1; n++) @(negedge clka);
            check($sformatf("t6_latency_%0d", i), lat, 32'd1);
            if (i == 3) check("t6_count_wrap", {30'd0, fetch_count1}, 32'd0);
        end
        check("t6_count_final", {30'd0, fetch_count1}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
